// File: rtl/bit_op_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, START/BUSY/DONE handshake.
// Programmable fill bits for logical/arithmetic shifts, carry-out of the last bit moved and a zero flag.
module bit_op_shift_unit #(
   parameter  int WIDTH = 16,
   localparam int AW    = $clog2(WIDTH)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_a,
   input  logic [AW-1:0]    i_amt,
   input  logic             i_fill_lo,
   input  logic             i_fill_hi,
   output logic [WIDTH-1:0] o_f,
   output logic             o_carry,
   output logic             o_zero,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [1:0] MODE_SHL = 2'd0;
   localparam logic [1:0] MODE_SHR = 2'd1;
   localparam logic [1:0] MODE_ROL = 2'd2;
   localparam logic [1:0] MODE_ROR = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FIN   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_data;
   logic [AW-1:0]    r_cnt;
   logic             r_carry;
   logic [1:0]       r_mode;
   logic             r_fillLo;
   logic             r_fillHi;
   logic [WIDTH-1:0] w_stepData;
   logic             w_stepCarry;
   logic             w_accept;

   assign w_accept = (r_state == S_IDLE) && i_start;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The remaining-count test uses the value before this edge's decrement.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_nextState = (i_amt == '0) ? S_FIN : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (r_cnt == AW'(1)) begin
               w_nextState = S_FIN;
            end
         end
         S_FIN: begin
            w_nextState = S_IDLE;
         end
         default: begin
            w_nextState = S_IDLE;
         end
      endcase
   end

   always_comb begin
      o_busy = (r_state != S_IDLE);
      o_done = (r_state == S_FIN);
   end

   always_comb begin
      w_stepData  = r_data;
      w_stepCarry = 1'b0;
      case (r_mode)
         MODE_SHL: begin
            w_stepData  = {r_data[WIDTH-2:0], r_fillLo};
            w_stepCarry = r_data[WIDTH-1];
         end
         MODE_SHR: begin
            w_stepData  = {r_fillHi, r_data[WIDTH-1:1]};
            w_stepCarry = r_data[0];
         end
         MODE_ROL: begin
            w_stepData  = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            w_stepCarry = r_data[WIDTH-1];
         end
         MODE_ROR: begin
            w_stepData  = {r_data[0], r_data[WIDTH-1:1]};
            w_stepCarry = r_data[0];
         end
         default: begin
            w_stepData  = r_data;
            w_stepCarry = 1'b0;
         end
      endcase
   end

   // Result and carry hold after FIN until the next accepted request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data   <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_mode   <= 2'd0;
         r_fillLo <= 1'b0;
         r_fillHi <= 1'b0;
      end else if (w_accept) begin
         r_data   <= i_a;
         r_cnt    <= i_amt;
         r_carry  <= 1'b0;
         r_mode   <= i_mode;
         r_fillLo <= i_fill_lo;
         r_fillHi <= i_fill_hi;
      end else if (r_state == S_SHIFT) begin
         r_data  <= w_stepData;
         r_cnt   <= r_cnt - AW'(1);
         r_carry <= w_stepCarry;
      end
   end

   assign o_f     = r_data;
   assign o_carry = r_carry;
   assign o_zero  = (r_data == '0);

endmodule

// File: tb/tb_bit_op_shift_unit.sv
// Scoreboard bench for bit_op_shift_unit: expected results queued at accept, popped on DONE.
module tb_bit_op_shift_unit;

   localparam int W  = 16;
   localparam int AW = 4;

   typedef struct {
      logic [W-1:0] f;
      logic         c;
      int           busyLen;
   } exp_t;

   logic          i_clk;
   logic          i_rst_n;
   logic          i_start;
   logic [1:0]    i_mode;
   logic [W-1:0]  i_a;
   logic [AW-1:0] i_amt;
   logic          i_fill_lo;
   logic          i_fill_hi;
   logic [W-1:0]  o_f;
   logic          o_carry;
   logic          o_zero;
   logic          o_busy;
   logic          o_done;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   busyCnt     = 0;

   bit_op_shift_unit #(.WIDTH(W)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_start   (i_start),
      .i_mode    (i_mode),
      .i_a       (i_a),
      .i_amt     (i_amt),
      .i_fill_lo (i_fill_lo),
      .i_fill_hi (i_fill_hi),
      .o_f       (o_f),
      .o_carry   (o_carry),
      .o_zero    (o_zero),
      .o_busy    (o_busy),
      .o_done    (o_done)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference behaviour stepped bit by bit from the operation definitions.
   function automatic exp_t model(input logic [1:0] mode, input logic [W-1:0] a,
                                  input int amt, input logic fl, input logic fh);
      exp_t e;
      logic [W-1:0] r;
      logic c;
      r = a;
      c = 1'b0;
      for (int i = 0; i < amt; i++) begin
         case (mode)
            2'd0: begin c = r[W-1]; r = r << 1; r[0] = fl; end
            2'd1: begin c = r[0]; r = r >> 1; r[W-1] = fh; end
            2'd2: begin c = r[W-1]; r = {r[W-2:0], r[W-1]}; end
            default: begin c = r[0]; r = {r[0], r[W-1:1]}; end
         endcase
      end
      e.f = r;
      e.c = c;
      e.busyLen = amt + 1;
      return e;
   endfunction

   always @(negedge i_clk) begin
      exp_t e;
      if (!i_rst_n) begin
         busyCnt = 0;
      end else begin
         if (o_busy) busyCnt++;
         else busyCnt = 0;
         if (o_done) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_done", 32'(o_done), 32'd0);
            end else begin
               e = sb.pop_front();
               checkOutput("result_f", 32'(o_f), 32'(e.f));
               checkOutput("carry", 32'(o_carry), 32'(e.c));
               checkOutput("zero", 32'(o_zero), 32'(e.f == '0));
               checkOutput("busy_len", 32'(busyCnt), 32'(e.busyLen));
            end
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] mode, input logic [W-1:0] a,
                                input logic [AW-1:0] amt, input logic fl, input logic fh);
      @(negedge i_clk);
      i_mode = mode; i_a = a; i_amt = amt; i_fill_lo = fl; i_fill_hi = fh;
      i_start = 1'b1;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      sb.push_back(model(mode, a, int'(amt), fl, fh));
   endtask

   task automatic waitDone(input int expLat);
      int n;
      bit got;
      n = 0;
      got = 0;
      while (n < expLat + 8 && !got) begin
         @(negedge i_clk);
         n++;
         if (o_done) got = 1;
      end
      if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
      else checkOutput("done_latency", 32'(n), 32'(expLat));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      exp_t e;
      i_rst_n = 1'b0; i_start = 1'b0; i_mode = 2'd0; i_a = '0; i_amt = '0;
      i_fill_lo = 1'b0; i_fill_hi = 1'b0;
      #3;
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_done", 32'(o_done), 32'd0);
      checkOutput("rst_f", 32'(o_f), 32'd0);
      checkOutput("rst_zero", 32'(o_zero), 32'd1);
      checkOutput("rst_carry", 32'(o_carry), 32'd0);
      @(negedge i_clk); @(negedge i_clk);
      i_rst_n = 1'b1;

      applyStimulus(2'd0, 16'h8001, 4'd1, 1'b1, 1'b0);  waitDone(2);
      applyStimulus(2'd3, 16'h0001, 4'd4, 1'b0, 1'b0);  waitDone(5);
      applyStimulus(2'd2, 16'h8000, 4'd1, 1'b0, 1'b0);  waitDone(2);
      applyStimulus(2'd1, 16'hF000, 4'd15, 1'b0, 1'b0); waitDone(16);
      applyStimulus(2'd1, 16'hF000, 4'd15, 1'b0, 1'b1); waitDone(16);
      e = model(2'd1, 16'hF000, 15, 1'b0, 1'b1);
      @(negedge i_clk); @(negedge i_clk);
      checkOutput("hold_f", 32'(o_f), 32'(e.f));
      checkOutput("hold_carry", 32'(o_carry), 32'(e.c));
      applyStimulus(2'd0, 16'h1234, 4'd0, 1'b1, 1'b1);  waitDone(1);
      applyStimulus(2'd0, 16'h8000, 4'd1, 1'b0, 1'b0);  waitDone(2);

      // START pulse mid-operation must be ignored.
      applyStimulus(2'd0, 16'h0F0F, 4'd5, 1'b0, 1'b0);
      @(negedge i_clk); @(negedge i_clk);
      i_start = 1'b1; i_a = 16'hAAAA; i_amt = 4'd0; i_mode = 2'd3;
      @(posedge i_clk);
      #1 i_start = 1'b0;
      waitDone(4);
      repeat (3) @(negedge i_clk);
      checkOutput("ignored_start_busy", 32'(o_busy), 32'd0);

      // START held high: second accept exactly two edges after the last shift.
      @(negedge i_clk);
      i_mode = 2'd2; i_a = 16'h1357; i_amt = 4'd5; i_fill_lo = 1'b0; i_fill_hi = 1'b0;
      i_start = 1'b1;
      sb.push_back(model(2'd2, 16'h1357, 5, 1'b0, 1'b0));
      sb.push_back(model(2'd1, 16'hC003, 2, 1'b0, 1'b1));
      @(posedge i_clk);
      #1 i_mode = 2'd1; i_a = 16'hC003; i_amt = 4'd2; i_fill_hi = 1'b1;
      waitDone(6);
      @(negedge i_clk);
      checkOutput("held_idle_gap", 32'(o_busy), 32'd0);
      @(negedge i_clk);
      checkOutput("held_reaccept", 32'(o_busy), 32'd1);
      i_start = 1'b0;
      waitDone(2);

      // Reset in the middle of a long shift.
      applyStimulus(2'd0, 16'h00FF, 4'd10, 1'b1, 1'b0);
      @(posedge i_clk); @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(o_busy), 32'd0);
      checkOutput("midrst_done", 32'(o_done), 32'd0);
      checkOutput("midrst_f", 32'(o_f), 32'd0);
      checkOutput("midrst_zero", 32'(o_zero), 32'd1);
      checkOutput("midrst_carry", 32'(o_carry), 32'd0);
      sb.delete();
      @(negedge i_clk);
      i_rst_n = 1'b1;
      applyStimulus(2'd0, 16'h0001, 4'd3, 1'b0, 1'b0);
      waitDone(4);

      for (int i = 0; i < 8; i++) begin
         logic [1:0]    m;
         logic [W-1:0]  a;
         logic [AW-1:0] amt;
         m   = 2'($urandom_range(0, 3));
         a   = 16'($urandom);
         amt = 4'($urandom_range(0, 15));
         applyStimulus(m, a, amt, 1'($urandom), 1'($urandom));
         waitDone(int'(amt) + 1);
      end

      @(negedge i_clk);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
